// File: rtl/crt_sync_capture_if.sv
// crt_sync_capture_if
//   Bundle between a 240p CRT video source / framebuffer and the capture block.
//   Video side : capture_en, crt_sync (composite, low = sync), crt_r/g/b.
//   Frame side : fb_addr/fb_data/fb_we write port, frame_done, frame_err, locked.
//   master : the source/framebuffer end (drives video, receives writes).
//   slave  : the capture block (receives video, drives writes and status).
interface crt_sync_capture_if;
  logic        capture_en;
  logic        crt_sync;
  logic [2:0]  crt_r;
  logic [2:0]  crt_g;
  logic [1:0]  crt_b;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        frame_done;
  logic        frame_err;
  logic        locked;

  modport master (
    output capture_en, crt_sync, crt_r, crt_g, crt_b,
    input  fb_addr, fb_data, fb_we, frame_done, frame_err, locked
  );

  modport slave (
    input  capture_en, crt_sync, crt_r, crt_g, crt_b,
    output fb_addr, fb_data, fb_we, frame_done, frame_err, locked
  );
endinterface

// File: rtl/crt_sync_capture.sv
// crt_sync_capture
//   Receive side of the 240p CRT video link. Separates hsync/vsync out of the
//   composite sync by low-pulse width, rebuilds line and pixel position and
//   writes every active pixel of a frame into a framebuffer write port.
// Ports
//   vga_clk     in   pixel clock
//   nreset      in   synchronous active-low reset
//   bus.slave        capture_en, crt_sync, crt_r/g/b in;
//                    fb_addr (y*H_RES+x), fb_data {r,g,b}, fb_we,
//                    frame_done, frame_err, locked out
module crt_sync_capture #(
  parameter int unsigned H_RES        = 320,
  parameter int unsigned V_RES        = 240,
  parameter int unsigned H_OFFSET     = 45,
  parameter int unsigned V_OFFSET     = 21,
  parameter int unsigned HSYNC_MIN    = 16,
  parameter int unsigned HSYNC_MAX    = 40,
  parameter int unsigned VSYNC_MIN    = 200,
  parameter int unsigned SYNC_TIMEOUT = 1000
) (
  input logic            vga_clk,
  input logic            nreset,
  crt_sync_capture_if.slave bus
);

  localparam int unsigned KW = $clog2(H_OFFSET + 1);
  localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [2:0] {SEARCH, VBLANK, HOLD, CAP, LINE, DONE} state_t;

  state_t        state;
  logic          csync_s;
  logic          csync_d;
  logic [7:0]    rgb_s;
  logic [9:0]    low_w;
  logic [TW-1:0] to_cnt;
  logic [8:0]    line_cnt;
  logic [KW-1:0] k;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [16:0]   addr;

  logic [16:0]   fb_addr;
  logic [7:0]    fb_data;
  logic          fb_we;
  logic          frame_done;
  logic          frame_err;
  logic          locked;

  logic          rise;
  logic          fall;
  logic          hs_ev;
  logic          vs_ev;
  logic          to_fire;
  logic          in_frame;
  logic          abort;

  always_comb begin
    rise     = csync_s & ~csync_d;
    fall     = ~csync_s & csync_d;
    // low_w holds the full low width on the first high cycle
    hs_ev    = rise && (low_w >= 10'(HSYNC_MIN)) && (low_w <= 10'(HSYNC_MAX));
    vs_ev    = rise && (low_w >= 10'(VSYNC_MIN));
    to_fire  = !hs_ev && !vs_ev && (to_cnt == TW'(SYNC_TIMEOUT - 1));
    in_frame = (state == HOLD) || (state == CAP) || (state == LINE);
    abort    = (fall && ((state == HOLD) || (state == CAP))) || (vs_ev && in_frame);
  end

  always_ff @(posedge vga_clk) begin
    if (!nreset) begin
      state      <= SEARCH;
      csync_s    <= 1'b1;
      csync_d    <= 1'b1;
      rgb_s      <= '0;
      low_w      <= '0;
      to_cnt     <= '0;
      line_cnt   <= '0;
      k          <= '0;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      fb_addr    <= '0;
      fb_data    <= '0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      // sync and colour share one register stage so they stay aligned
      csync_s <= bus.crt_sync;
      csync_d <= csync_s;
      rgb_s   <= {bus.crt_r, bus.crt_g, bus.crt_b};

      if (!csync_s) begin
        if (csync_d) begin
          low_w <= 10'd1;
        end else if (low_w != '1) begin
          low_w <= low_w + 10'd1;
        end
      end

      if (vs_ev) begin
        line_cnt <= '0;
      end else if (hs_ev) begin
        line_cnt <= line_cnt + 9'd1;
      end

      if (hs_ev || vs_ev) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(SYNC_TIMEOUT)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (abort || to_fire) begin
        // an aborting vsync is deliberately not reused to start a capture
        frame_err <= abort || in_frame;
        locked    <= 1'b0;
        state     <= SEARCH;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_ev && bus.capture_en) begin
              state <= VBLANK;
              addr  <= '0;
            end
          end
          VBLANK: begin
            if (hs_ev && (line_cnt == 9'(V_OFFSET - 1))) begin
              state <= HOLD;
              y     <= '0;
              k     <= KW'(1);
            end
          end
          HOLD: begin
            // the hsync cycle itself is k=0, so CAP starts on the cycle
            // k would reach H_OFFSET, when rgb_s already holds pixel 0
            if (k == KW'(H_OFFSET - 1)) begin
              state <= CAP;
              x     <= '0;
            end else begin
              k <= k + KW'(1);
            end
          end
          CAP: begin
            fb_we   <= 1'b1;
            fb_addr <= addr;
            fb_data <= rgb_s;
            addr    <= addr + 17'd1;
            x       <= x + 9'd1;
            if (x == 9'(H_RES - 1)) begin
              state <= (y == 8'(V_RES - 1)) ? DONE : LINE;
            end
          end
          LINE: begin
            if (hs_ev) begin
              state <= HOLD;
              y     <= y + 8'd1;
              k     <= KW'(1);
            end
          end
          DONE: begin
            frame_done <= 1'b1;
            locked     <= 1'b1;
            if (vs_ev && bus.capture_en) begin
              state <= VBLANK;
              addr  <= '0;
            end else begin
              state <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.fb_addr    = fb_addr;
  assign bus.fb_data    = fb_data;
  assign bus.fb_we      = fb_we;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
  assign bus.locked     = locked;

endmodule
